dadda_reduce_pipe: RTL and testbench

Pipelined front end of the 8x8 unsigned Dadda multiplier: it accepts operand pairs over a valid/ready handshake, generates the 64 partial-product bits, and reduces them through the Dadda height sequence 8→6→4→3→2. It sits directly upstream of the 14-bit carry-select final adder. It presents two registered 14-bit rows covering product bits 14:1, plus the pass-through product bit 0. The final adder consumes the rows and its carry-out forms product bit 15.

---
 rtl/dadda_pkg.sv | 175 +++++++++++++++++
 rtl/dadda_reduce_pipe_if.sv | 24 ++
 rtl/dadda_pp_gen.sv | 21 ++
 rtl/dadda_reduce_pipe.sv | 78 +++++++
 tb/tb_dadda_reduce_pipe.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/dadda_pkg.sv
// Shared constants, types and reduction helpers for the 8x8 Dadda multiplier front end.
// Builds with and without DADDA_REDUCE_MID_REG_EN use the same functions.
package dadda_pkg;

  localparam int OP_W     = 8;
  localparam int ROW_W    = 14;
  localparam int COLS     = 2 * OP_W;
  localparam int MAX_H    = OP_W;
  localparam int MID_ROWS = 4;

  localparam int STAGE_H6 = 6;
  localparam int STAGE_H4 = 4;
  localparam int STAGE_H3 = 3;
  localparam int STAGE_H2 = 2;

  // Bit matrix indexed [column][slot]; live bits are packed from slot 0 and unused slots are zero.
  typedef logic [MAX_H-1:0] col_t;
  typedef col_t [COLS-1:0]  pp_mat_t;
  typedef logic [COLS-1:0][3:0] hvec_t;

  typedef logic [MID_ROWS-1:0][2*OP_W-1:0] mid_rows_t;

  typedef struct packed {
    logic [ROW_W-1:0] row_a;
    logic [ROW_W-1:0] row_b;
    logic             p0;
  } out_beat_t;

  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (z & (x ^ y)), x ^ y ^ z};
  endfunction

  function automatic int excess(input int he, input int d);
    return (he > d) ? he - d : 0;
  endfunction

  function automatic hvec_t pp_heights();
    hvec_t h;
    h = '0;
    for (int i = 0; i < OP_W; i++) begin
      for (int j = 0; j < OP_W; j++) begin
        h[4'(i + j)] = h[4'(i + j)] + 4'd1;
      end
    end
    return h;
  endfunction

  // Column heights after one stage: every column ends at min(height, d) and passes
  // ceil(excess/2) carries to its left neighbour.
  function automatic hvec_t next_heights(input hvec_t h, input int d);
    hvec_t o;
    int    cy;
    int    he;
    int    ex;
    o  = '0;
    cy = 0;
    for (int c = 0; c < COLS; c++) begin
      he         = int'(h[4'(c)]) + cy;
      ex         = excess(he, d);
      o[4'(c)]   = 4'(he - 2 * (ex / 2) - (ex % 2));
      cy         = (ex / 2) + (ex % 2);
    end
    return o;
  endfunction

  // One Dadda stage: the fewest full adders (plus at most one half adder) per column that
  // bring the column, counting carries arriving from the right, down to height d.
  function automatic pp_mat_t dadda_stage(input pp_mat_t m, input hvec_t h, input int d);
    pp_mat_t    o;
    col_t       cy_in;
    col_t       cy_out;
    int         n_in;
    int         n_out;
    int         he;
    int         ex;
    int         src;
    int         dst;
    logic [1:0] r;
    o     = '0;
    cy_in = '0;
    n_in  = 0;
    for (int c = 0; c < COLS; c++) begin
      he     = int'(h[4'(c)]) + n_in;
      ex     = excess(he, d);
      cy_out = '0;
      n_out  = 0;
      src    = 0;
      dst    = 0;
      for (int f = 0; f < 3; f++) begin
        if (f < ex / 2) begin
          r = fa(m[4'(c)][3'(src)], m[4'(c)][3'(src + 1)], m[4'(c)][3'(src + 2)]);
          o[4'(c)][3'(dst)]  = r[0];
          cy_out[3'(n_out)]  = r[1];
          src   += 3;
          dst   += 1;
          n_out += 1;
        end
      end
      if (ex % 2 == 1) begin
        r = ha(m[4'(c)][3'(src)], m[4'(c)][3'(src + 1)]);
        o[4'(c)][3'(dst)] = r[0];
        cy_out[3'(n_out)] = r[1];
        src   += 2;
        dst   += 1;
        n_out += 1;
      end
      for (int k = 0; k < MAX_H; k++) begin
        if (k >= src && k < int'(h[4'(c)])) begin
          o[4'(c)][3'(dst)] = m[4'(c)][3'(k)];
          dst += 1;
        end
      end
      for (int k = 0; k < MAX_H; k++) begin
        if (k < n_in) begin
          o[4'(c)][3'(dst)] = cy_in[3'(k)];
          dst += 1;
        end
      end
      cy_in = cy_out;
      n_in  = n_out;
    end
    return o;
  endfunction

  localparam hvec_t H_PP = pp_heights();
  localparam hvec_t H_S6 = next_heights(H_PP, STAGE_H6);
  localparam hvec_t H_S4 = next_heights(H_S6, STAGE_H4);
  localparam hvec_t H_S3 = next_heights(H_S4, STAGE_H3);

  function automatic mid_rows_t to_rows(input pp_mat_t m);
    mid_rows_t r;
    r = '0;
    for (int k = 0; k < MID_ROWS; k++) begin
      for (int c = 0; c < COLS; c++) begin
        r[2'(k)][4'(c)] = m[4'(c)][3'(k)];
      end
    end
    return r;
  endfunction

  function automatic pp_mat_t from_rows(input mid_rows_t r);
    pp_mat_t m;
    m = '0;
    for (int k = 0; k < MID_ROWS; k++) begin
      for (int c = 0; c < COLS; c++) begin
        m[4'(c)][3'(k)] = r[2'(k)][4'(c)];
      end
    end
    return m;
  endfunction

  // Column 0 stays a lone bit through every stage; columns 14:1 hold two bits each.
  function automatic out_beat_t to_beat(input pp_mat_t m);
    out_beat_t b;
    b.p0 = m[0][0];
    for (int i = 0; i < ROW_W; i++) begin
      b.row_a[4'(i)] = m[4'(i + 1)][0];
      b.row_b[4'(i)] = m[4'(i + 1)][1];
    end
    return b;
  endfunction

  function automatic mid_rows_t reduce_front(input pp_mat_t pp);
    return to_rows(dadda_stage(dadda_stage(pp, H_PP, STAGE_H6), H_S6, STAGE_H4));
  endfunction

  function automatic out_beat_t reduce_back(input mid_rows_t rows);
    return to_beat(dadda_stage(dadda_stage(from_rows(rows), H_S4, STAGE_H3), H_S3, STAGE_H2));
  endfunction

endpackage

// File: rtl/dadda_reduce_pipe_if.sv
// Operand/row stream bundle for dadda_reduce_pipe: slave is the reducer, master its environment.
interface dadda_reduce_pipe_if;
  import dadda_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] row_a;
  logic [ROW_W-1:0] row_b;
  logic             p0;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, row_a, row_b, p0
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, row_a, row_b, p0
  );
endinterface

// File: rtl/dadda_pp_gen.sv
// Partial-product generator: 64 AND terms packed per column from slot 0 upward.
module dadda_pp_gen
  import dadda_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output pp_mat_t         pp
);

  always_comb begin
    // NOTE: pp gets a full default first, so no slot is left unassigned on any path and no latch is inferred.
    pp = '0;
    for (int i = 0; i < OP_W; i++) begin
      for (int j = 0; j < OP_W; j++) begin
        // Right half of the matrix slots by row index, left half by (OP_W-1-j), keeping columns dense.
        pp[4'(i + j)][3'((i + j < OP_W) ? i : OP_W - 1 - j)] = a[3'(i)] & b[3'(j)];
      end
    end
  end

endmodule

// File: rtl/dadda_reduce_pipe.sv
// Pipelined Dadda reduction (8->6->4->3->2) of an 8x8 product into two 14-bit rows plus p0.
// Define DADDA_REDUCE_MID_REG_EN to register the 4-row intermediate (latency 2 instead of 1).
module dadda_reduce_pipe
  import dadda_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  dadda_reduce_pipe_if.slave bus
);

  pp_mat_t   pp;
  mid_rows_t front_rows;
  mid_rows_t back_rows;
  out_beat_t back_beat;
  out_beat_t out_beat_q;
  logic      out_valid_q;
  logic      out_load;
  logic      up_valid;

  dadda_pp_gen u_pp_gen (
    .a  (bus.in_a),
    .b  (bus.in_b),
    .pp (pp)
  );

  assign front_rows = reduce_front(pp);
  assign back_beat  = reduce_back(back_rows);

  // The output register refills when empty or when its beat is being taken.
  assign out_load = !out_valid_q || bus.out_ready;

`ifdef DADDA_REDUCE_MID_REG_EN
  logic      mid_valid_q;
  logic      mid_load;
  mid_rows_t mid_rows_q;

  assign mid_load     = !mid_valid_q || out_load;
  assign bus.in_ready = !rst && mid_load;
  assign back_rows    = mid_rows_q;
  assign up_valid     = mid_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mid_valid_q <= 1'b0;
      mid_rows_q  <= '0;
    end else if (mid_load) begin
      mid_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        mid_rows_q <= front_rows;
      end
    end
  end
`else
  assign bus.in_ready = !rst && out_load;
  assign back_rows    = front_rows;
  assign up_valid     = bus.in_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data is cleared along with the valid flag so a flushed pipe shows all-zero rows.
      out_valid_q <= 1'b0;
      out_beat_q  <= '0;
    end else if (out_load) begin
      // NOTE: state updates use <= so each register samples its inputs as they were before the edge.
      out_valid_q <= up_valid;
      if (up_valid) begin
        out_beat_q <= back_beat;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.row_a     = out_beat_q.row_a;
  assign bus.row_b     = out_beat_q.row_b;
  assign bus.p0        = out_beat_q.p0;

endmodule

// File: tb/tb_dadda_reduce_pipe.sv
// Self-checking bench for dadda_reduce_pipe: product table, stream, stall, reset flush, random traffic.
// Expected latency follows DADDA_REDUCE_MID_REG_EN.
module tb_dadda_reduce_pipe;
  import dadda_pkg::*;

`ifdef DADDA_REDUCE_MID_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        p0;
    logic [14:0] sum;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dadda_reduce_pipe_if bus ();

  dadda_reduce_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_out_beats = 0;
  logic [15:0] exp_q[$];
  bit          acc_in;
  bit          acc_out;
  logic [15:0] got;

  function automatic logic [15:0] beat_product(input logic [13:0] ra, input logic [13:0] rb,
                                               input logic p);
    logic [14:0] s;
    s = 15'(ra) + 15'(rb);
    return {s, p};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // One clock: drive at the falling edge, observe 1ns later, score what transfers on the next rise.
  task automatic cycle(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic ordy);
    @(negedge clk);
    rst           = r;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = ordy;
    #1;
    acc_in  = !r && (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
    acc_out = !r && (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
    got     = beat_product(bus.row_a, bus.row_b, bus.p0);
    if (acc_out) begin
      n_out_beats++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected beat: got product 0x%04h, expected no beat", got);
      end else begin
        check("beat product", 32'(got), 32'(exp_q.pop_front()));
      end
    end
    if (r) exp_q.delete();
    else if (acc_in) exp_q.push_back({8'd0, a} * {8'd0, b});
  endtask

  initial begin
    vec_t        tbl[6];
    logic [7:0]  sa[3];
    logic [7:0]  sb[3];
    logic [15:0] stream_exp[3];
    logic [28:0] snap;
    int          k;
    int          mask;
    int          n_seen;
    int          base;
    int          sent;
    int          cyc;
    bit          b_done;

    tbl[0] = '{a: 8'hFF, b: 8'hFF, p0: 1'b1, sum: 15'h7F00};
    tbl[1] = '{a: 8'h00, b: 8'hA5, p0: 1'b0, sum: 15'h0000};
    tbl[2] = '{a: 8'h01, b: 8'h01, p0: 1'b1, sum: 15'h0000};
    tbl[3] = '{a: 8'h12, b: 8'h34, p0: 1'b0, sum: 15'h01D4};
    tbl[4] = '{a: 8'h80, b: 8'h80, p0: 1'b0, sum: 15'h2000};
    tbl[5] = '{a: 8'h7F, b: 8'h03, p0: 1'b1, sum: 15'h00BE};
    sa = '{8'h12, 8'h80, 8'h7F};
    sb = '{8'h34, 8'h80, 8'h03};
    stream_exp = '{16'h03A8, 16'h4000, 16'h017D};

    // Reset state
    cycle(1, 0, 8'd0, 8'd0, 0);
    check("in_ready during reset", 32'(bus.in_ready), 32'd0);
    cycle(1, 0, 8'd0, 8'd0, 0);
    cycle(0, 0, 8'd0, 8'd0, 0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset row_a", 32'(bus.row_a), 32'd0);
    check("reset row_b", 32'(bus.row_b), 32'd0);
    check("reset p0", 32'(bus.p0), 32'd0);
    check("in_ready after reset", 32'(bus.in_ready), 32'd1);

    // Table: single beats, latency and row shape
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, tbl[i].a, tbl[i].b, 0);
      check("table accept", 32'(acc_in), 32'd1);
      k = 0;
      do begin
        cycle(0, 0, 8'd0, 8'd0, 0);
        k++;
      end while (bus.out_valid !== 1'b1 && k < 8);
      check("table latency", 32'(k), 32'(LAT));
      check("table p0", 32'(bus.p0), 32'(tbl[i].p0));
      check("table row sum", 32'(15'(bus.row_a) + 15'(bus.row_b)), 32'(tbl[i].sum));
      if (tbl[i].sum == 15'd0) check("table rows zero", 32'({bus.row_a, bus.row_b}), 32'd0);
      cycle(0, 0, 8'd0, 8'd0, 1);
      check("table drain", 32'(acc_out), 32'd1);
    end

    // Back-to-back stream with out_ready held high
    mask   = 0;
    n_seen = 0;
    for (int i = 0; i < 3 + LAT + 2; i++) begin
      if (i < 3) begin
        cycle(0, 1, sa[i], sb[i], 1);
        check("stream accept", 32'(acc_in), 32'd1);
      end else begin
        cycle(0, 0, 8'd0, 8'd0, 1);
      end
      if (acc_out) begin
        mask |= (1 << i);
        if (n_seen < 3) check("stream order", 32'(got), 32'(stream_exp[n_seen]));
        n_seen++;
      end
    end
    check("stream cadence", 32'(mask), 32'(7 << LAT));

    // Stall: out_ready low for three edges with a full pipe
    base   = n_out_beats;
    b_done = 1'b0;
    cycle(0, 1, 8'h5A, 8'hC3, 0);
    for (int i = 0; i < LAT + 3; i++) begin
      cycle(0, !b_done, 8'h3C, 8'h99, 0);
      if (acc_in) b_done = 1'b1;
      if (i == LAT - 1) begin
        snap = {bus.row_a, bus.row_b, bus.p0};
        check("stall head product", 32'(beat_product(snap[28:15], snap[14:1], snap[0])),
              32'(16'h005A * 16'h00C3));
      end
      if (i >= LAT - 1) begin
        check("stall out_valid", 32'(bus.out_valid), 32'd1);
        check("stall in_ready", 32'(bus.in_ready), 32'd0);
        check("stall rows stable", 32'({bus.row_a, bus.row_b, bus.p0}), 32'(snap));
      end
    end
    cycle(0, !b_done, 8'h3C, 8'h99, 1);
    check("stall release", 32'(acc_out), 32'd1);
    for (int i = 0; i < LAT + 2; i++) cycle(0, 0, 8'd0, 8'd0, 1);
    check("stall beat count", 32'(n_out_beats - base), 32'd2);
    check("stall queue empty", 32'(exp_q.size()), 32'd0);

    // Reset with beats in flight
    base = n_out_beats;
    cycle(0, 1, 8'hE7, 8'h55, 0);
    cycle(0, 1, 8'h19, 8'hB2, 0);
    cycle(1, 0, 8'd0, 8'd0, 1);
    check("flush in_ready", 32'(bus.in_ready), 32'd0);
    cycle(0, 0, 8'd0, 8'd0, 1);
    check("flush out_valid", 32'(bus.out_valid), 32'd0);
    check("flush rows", 32'({bus.row_a, bus.row_b, bus.p0}), 32'd0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 8'd0, 8'd0, 1);
    check("flushed beats absent", 32'(n_out_beats - base), 32'd0);

    // Random traffic against the product model
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      cycle(0, ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 2) != 0));
      if (acc_in) sent++;
      cyc++;
    end
    check("random accepted", 32'(sent), 32'd10000);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      cycle(0, 0, 8'd0, 8'd0, 1);
      cyc++;
    end
    check("random drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
